// File: rtl/sdram_port_arbiter_if.sv
// Client-side toggle ports and the single SDRAM controller port shared by the arbiter.
// Packed per-client fields sit at [i*W +: W].
interface sdram_port_arbiter_if #(parameter int NREQ = 2);
  logic [NREQ-1:0]      c_req;
  logic [NREQ-1:0]      c_ack;
  logic [NREQ*22-1:0]   c_addr;
  logic [NREQ*2-1:0]    c_ds;
  logic [NREQ-1:0]      c_we;
  logic [NREQ*16-1:0]   c_din;
  logic [NREQ*16-1:0]   c_dout;
  logic [1:0]           grant;
  logic                 busy;
  logic [21:0]          mem_addr;
  logic                 mem_req;
  logic [1:0]           mem_ds;
  logic                 mem_we;
  logic [15:0]          mem_din;
  logic                 mem_req_ack;
  logic [15:0]          mem_dout;

  modport slave (
    input  c_req, c_addr, c_ds, c_we, c_din, mem_req_ack, mem_dout,
    output c_ack, c_dout, grant, busy, mem_addr, mem_req, mem_ds, mem_we, mem_din
  );

  modport master (
    output c_req, c_addr, c_ds, c_we, c_din, mem_req_ack, mem_dout,
    input  c_ack, c_dout, grant, busy, mem_addr, mem_req, mem_ds, mem_we, mem_din
  );
endinterface

// File: rtl/sdram_port_arbiter.sv
// Arbitrates NREQ toggle-handshake clients onto one SDRAM controller port.
// One transaction in flight; per-client ack/read-data live in slot instances.
module sdram_port_slot (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cmpl,
  input  logic        capture,
  input  logic [15:0] rdata,
  output logic        ack,
  output logic [15:0] dout
);
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ack  <= 1'b0;
      dout <= '0;
    end else if (cmpl) begin
      ack <= ~ack;
      if (capture) dout <= rdata;
    end
  end
endmodule

module sdram_port_arbiter #(
  parameter int NREQ = 2,
  parameter bit RR   = 1'b1
) (
  input logic            clk,
  input logic            resetn,
  sdram_port_arbiter_if.slave bus
);
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t                 state, state_nxt;
  logic [NREQ-1:0]        ack_v, pending, take;
  logic [NREQ-1:0][15:0]  dout_v;
  logic [1:0]             last, win;
  logic                   load, cmpl, done;

  // Round-robin scans upward from the slot after the last winner.
  function automatic logic [1:0] pick(input logic [NREQ-1:0] p, input logic [1:0] l);
    logic [1:0] w;
    logic       f;
    w = '0;
    f = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = RR ? (int'(l) + 1 + k) % NREQ : k;
      if (!f && p[idx]) begin
        w = 2'(idx);
        f = 1'b1;
      end
    end
    return w;
  endfunction

  assign pending = bus.c_req ^ ack_v;
  assign win     = pick(pending, last);
  assign done    = (bus.mem_req_ack == bus.mem_req);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (|pending) state_nxt = BUSY;
      BUSY: if (done)     state_nxt = IDLE;
    endcase
  end

  always_comb begin
    load = 1'b0;
    cmpl = 1'b0;
    case (state)
      IDLE: load = |pending;
      BUSY: cmpl = done;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bus.mem_addr <= '0;
      bus.mem_req  <= 1'b0;
      bus.mem_ds   <= '0;
      bus.mem_we   <= 1'b0;
      bus.mem_din  <= '0;
      bus.grant    <= '0;
      bus.busy     <= 1'b0;
      last         <= 2'(NREQ - 1);
    end else if (load) begin
      bus.mem_addr <= bus.c_addr[win*22 +: 22];
      bus.mem_ds   <= bus.c_ds[win*2 +: 2];
      bus.mem_we   <= bus.c_we[win];
      bus.mem_din  <= bus.c_din[win*16 +: 16];
      bus.mem_req  <= ~bus.mem_req;
      bus.grant    <= win;
      bus.busy     <= 1'b1;
    end else if (cmpl) begin
      last     <= bus.grant;
      bus.busy <= 1'b0;
    end
  end

  for (genvar i = 0; i < NREQ; i++) begin : g_slot
    assign take[i] = cmpl && (bus.grant == 2'(i));
    sdram_port_slot u_slot (
      .clk     (clk),
      .resetn  (resetn),
      .cmpl    (take[i]),
      .capture (~bus.mem_we),
      .rdata   (bus.mem_dout),
      .ack     (ack_v[i]),
      .dout    (dout_v[i])
    );
  end

  assign bus.c_ack  = ack_v;
  assign bus.c_dout = dout_v;
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed and random checks of the SDRAM port arbiter against a controller model
// and an expected-result scoreboard; a second fixed-priority instance covers RR=0.
module tb_sdram_port_arbiter;
  localparam int NA = 4;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  sdram_port_arbiter_if #(.NREQ(NA)) ifa ();
  sdram_port_arbiter_if #(.NREQ(2))  ifb ();

  sdram_port_arbiter #(.NREQ(NA), .RR(1'b1)) dut_a (.clk(clk), .resetn(resetn), .bus(ifa));
  sdram_port_arbiter #(.NREQ(2),  .RR(1'b0)) dut_b (.clk(clk), .resetn(resetn), .bus(ifb));

  typedef struct { logic we; logic [15:0] data; } exp_t;

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, n_done = 0;
  int lat_sel = 3;
  exp_t expq [NA][$];
  int   glog[$], gcyc[$];
  int   ack_cyc[NA], waitc[NA];
  logic [NA-1:0]      p_ack;
  logic [NA*16-1:0]   p_dout;
  logic               p_mreq;
  logic [15:0] smem [0:1023];
  logic        swr  [0:1023];
  logic [15:0] cmem [0:1023];
  logic        cwr  [0:1023];
  int cnt_a, cnt_b;

  function automatic logic [15:0] dflt(input logic [21:0] a);
    return a[15:0] ^ 16'hBFEF ^ {10'b0, a[21:16]};
  endfunction
  function automatic int sidx(input logic [21:0] a);
    return int'({a[21:20], a[7:0]});
  endfunction
  function automatic logic [15:0] merge(input logic [15:0] o, input logic [15:0] d, input logic [1:0] ds);
    return {ds[1] ? d[15:8] : o[15:8], ds[0] ? d[7:0] : o[7:0]};
  endfunction

  // Controller model for instance A: latency lat_sel cycles (0 = random 1..8).
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ifa.mem_req_ack <= 1'b0;
      ifa.mem_dout    <= '0;
      cnt_a           <= 0;
      for (int k = 0; k < 1024; k++) cwr[k] <= 1'b0;
    end else if (cnt_a > 1) begin
      cnt_a <= cnt_a - 1;
    end else if (cnt_a == 1) begin
      cnt_a <= 0;
      ifa.mem_req_ack <= ifa.mem_req;
      if (ifa.mem_we) begin
        cmem[sidx(ifa.mem_addr)] <= merge(cwr[sidx(ifa.mem_addr)] ? cmem[sidx(ifa.mem_addr)] : dflt(ifa.mem_addr),
                                          ifa.mem_din, ifa.mem_ds);
        cwr[sidx(ifa.mem_addr)]  <= 1'b1;
      end else begin
        ifa.mem_dout <= cwr[sidx(ifa.mem_addr)] ? cmem[sidx(ifa.mem_addr)] : dflt(ifa.mem_addr);
      end
    end else if (ifa.mem_req != ifa.mem_req_ack) begin
      cnt_a <= (lat_sel == 0) ? int'($urandom_range(8, 1)) : lat_sel;
    end
  end

  // Controller model for instance B: fixed latency, read data = low address bits.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ifb.mem_req_ack <= 1'b0;
      ifb.mem_dout    <= '0;
      cnt_b           <= 0;
    end else if (cnt_b > 1) begin
      cnt_b <= cnt_b - 1;
    end else if (cnt_b == 1) begin
      cnt_b <= 0;
      ifb.mem_req_ack <= ifb.mem_req;
      ifb.mem_dout    <= ifb.mem_addr[15:0];
    end else if (ifb.mem_req != ifb.mem_req_ack) begin
      cnt_b <= 2;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic mon();
    exp_t e;
    logic [NA-1:0] pend;
    cyc++;
    if (resetn) begin
      pend = ifa.c_req ^ ifa.c_ack;
      if (ifa.mem_req != p_mreq) begin
        glog.push_back(int'(ifa.grant));
        gcyc.push_back(cyc);
        for (int i = 0; i < NA; i++) begin
          if (i == int'(ifa.grant)) waitc[i] = 0;
          else if (pend[i]) begin
            waitc[i]++;
            chk("starvation", waitc[i] <= 3, 1);
          end
        end
      end
      for (int i = 0; i < NA; i++) begin
        if (ifa.c_ack[i] != p_ack[i]) begin
          ack_cyc[i] = cyc;
          n_done++;
          chk("sb_nonempty", expq[i].size() != 0, 1);
          if (expq[i].size() != 0) begin
            e = expq[i].pop_front();
            if (!e.we) chk("rdata", ifa.c_dout[i*16 +: 16], e.data);
            else       chk("wr_dout_keep", ifa.c_dout[i*16 +: 16], p_dout[i*16 +: 16]);
          end
        end else begin
          chk("dout_hold", ifa.c_dout[i*16 +: 16], p_dout[i*16 +: 16]);
        end
      end
    end
    p_ack  = ifa.c_ack;
    p_dout = ifa.c_dout;
    p_mreq = ifa.mem_req;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    mon();
  endtask

  task automatic issue(input int c, input logic we, input logic [21:0] a,
                       input logic [1:0] ds, input logic [15:0] d);
    int k;
    exp_t e;
    logic [15:0] old;
    chk("proto_no_reissue", ifa.c_req[c] ^ ifa.c_ack[c], 0);
    k   = sidx(a);
    old = swr[k] ? smem[k] : dflt(a);
    ifa.c_addr[c*22 +: 22] = a;
    ifa.c_ds[c*2 +: 2]     = ds;
    ifa.c_we[c]            = we;
    ifa.c_din[c*16 +: 16]  = d;
    e.we   = we;
    e.data = we ? 16'h0 : old;
    if (we) begin
      smem[k] = merge(old, d, ds);
      swr[k]  = 1'b1;
    end
    expq[c].push_back(e);
    ifa.c_req[c] = ~ifa.c_req[c];
  endtask

  task automatic wait_ack(input int c);
    int n;
    n = 0;
    while (ifa.c_ack[c] != ifa.c_req[c] && n < 100) begin tick(); n++; end
    chk("ack_timeout_a", n < 100, 1);
  endtask

  task automatic wait_ack_b(input int c);
    int n;
    n = 0;
    while (ifb.c_ack[c] != ifb.c_req[c] && n < 100) begin tick(); n++; end
    chk("ack_timeout_b", n < 100, 1);
  endtask

  task automatic rst_assert();
    resetn = 1'b0;
    ifa.c_req = '0;
    ifb.c_req = '0;
  endtask

  task automatic rst_release();
    tick();
    tick();
    #2 resetn = 1'b1;
    for (int i = 0; i < NA; i++) begin expq[i].delete(); waitc[i] = 0; end
    for (int k = 0; k < 1024; k++) swr[k] = 1'b0;
    glog.delete();
    gcyc.delete();
  endtask

  initial begin
    int n, issued, done0;
    logic mr;
    ifa.c_req = '0; ifa.c_addr = '0; ifa.c_ds = '0; ifa.c_we = '0; ifa.c_din = '0;
    ifb.c_req = '0; ifb.c_addr = '0; ifb.c_ds = '0; ifb.c_we = '0; ifb.c_din = '0;
    p_ack = '0; p_dout = '0; p_mreq = 1'b0;
    for (int k = 0; k < 1024; k++) swr[k] = 1'b0;
    rst_release();

    // reset state
    chk("rst_mem_req", ifa.mem_req, 0);
    chk("rst_mem_addr", ifa.mem_addr, 0);
    chk("rst_c_ack", ifa.c_ack, 0);
    chk("rst_c_dout", ifa.c_dout[31:0], 0);
    chk("rst_busy_grant", {ifa.busy, ifa.grant}, 0);

    // client 0 read: one-cycle request latency, 0xBEEF returned
    issue(0, 1'b0, 22'h000100, 2'b11, 16'h0);
    chk("req_lat_before", ifa.mem_req, 0);
    tick();
    chk("req_lat_after", ifa.mem_req, 1);
    chk("grant0", {ifa.busy, ifa.grant}, {1'b1, 2'd0});
    chk("fwd_addr0", ifa.mem_addr, 22'h000100);
    wait_ack(0);
    chk("beef", ifa.c_dout[15:0], 16'hBEEF);
    chk("dout1_zero", ifa.c_dout[31:16], 0);

    // client 1 write at top address, held stable until ack
    issue(1, 1'b1, 22'h3FFFFF, 2'b10, 16'h1234);
    tick();
    n = 0;
    while (ifa.c_ack[1] != ifa.c_req[1] && n < 100) begin
      chk("wr_fields", {ifa.mem_addr, ifa.mem_ds, ifa.mem_we, ifa.mem_din},
          {22'h3FFFFF, 2'b10, 1'b1, 16'h1234});
      chk("wr_grant", ifa.grant, 1);
      tick();
      n++;
    end
    chk("wr_timeout", n < 100, 1);
    chk("wr_dout1_unch", ifa.c_dout[31:16], 0);

    // simultaneous toggles after reset: 0 then 1, twice
    #2 rst_assert();
    rst_release();
    for (int r = 0; r < 2; r++) begin
      glog.delete(); gcyc.delete();
      issue(0, 1'b0, 22'h000010, 2'b11, 16'h0);
      issue(1, 1'b0, 22'h000020, 2'b11, 16'h0);
      wait_ack(0);
      wait_ack(1);
      chk("simul_cnt", glog.size(), 2);
      chk("simul_first", glog[0], 0);
      chk("simul_second", glog[1], 1);
      chk("b2b_gap", gcyc[1] - ack_cyc[0], 1);
      tick();
    end

    // client 1 arrives while 0 is busy
    issue(0, 1'b0, 22'h000030, 2'b11, 16'h0);
    tick();
    issue(1, 1'b1, 22'h000040, 2'b01, 16'hA55A);
    mr = ifa.mem_req;
    n = 0;
    while (ifa.c_ack[0] != ifa.c_req[0] && n < 100) begin
      chk("hold_mem_req", ifa.mem_req, mr);
      tick();
      n++;
    end
    chk("busy_timeout", n < 100, 1);
    chk("gap_busy_low", {ifa.busy, ifa.mem_req}, {1'b0, mr});
    tick();
    chk("next_grant", {ifa.busy, ifa.grant, ifa.mem_req}, {1'b1, 2'd1, ~mr});
    wait_ack(1);

    // RR: after 0 completes with 0 and 1 both pending, 1 wins
    tick();
    issue(0, 1'b0, 22'h000050, 2'b11, 16'h0);
    tick();
    issue(1, 1'b0, 22'h000060, 2'b11, 16'h0);
    wait_ack(0);
    issue(0, 1'b0, 22'h000070, 2'b11, 16'h0);
    tick();
    chk("rr_rotate", ifa.grant, 1);
    wait_ack(1);
    wait_ack(0);

    // fixed priority instance: client 0 always wins
    ifb.c_addr = {22'h001DEF, 22'h000ABC};
    ifb.c_ds = 4'hF;
    ifb.c_req = 2'b11;
    tick();
    chk("fp_first", {ifb.busy, ifb.grant}, {1'b1, 2'd0});
    wait_ack_b(0);
    chk("fp_dout0", ifb.c_dout[15:0], 16'h0ABC);
    tick();
    chk("fp_second", {ifb.busy, ifb.grant}, {1'b1, 2'd1});
    wait_ack_b(1);
    chk("fp_dout1", ifb.c_dout[31:16], 16'h1DEF);
    ifb.c_req[0] = ~ifb.c_req[0];
    tick();
    ifb.c_req[1] = ~ifb.c_req[1];
    wait_ack_b(0);
    ifb.c_req[0] = ~ifb.c_req[0];
    tick();
    chk("fp_zero_wins", ifb.grant, 0);
    wait_ack_b(0);
    wait_ack_b(1);

    // asynchronous reset mid-transaction
    #2 rst_assert();
    rst_release();
    issue(0, 1'b0, 22'h000200, 2'b11, 16'h0);
    tick();
    tick();
    chk("pre_rst_busy", {ifa.busy, ifa.mem_req}, 2'b11);
    #3 rst_assert();
    #1;
    chk("async_rst", {ifa.mem_req, ifa.busy, ifa.c_ack}, 0);
    rst_release();
    issue(0, 1'b0, 22'h000100, 2'b11, 16'h0);
    wait_ack(0);
    chk("post_rst_read", ifa.c_dout[15:0], 16'hBEEF);

    // random traffic, 1000 ops, random latency
    lat_sel = 0;
    issued = 0;
    done0 = n_done;
    n = 0;
    while ((issued < 1000 || ifa.c_req != ifa.c_ack) && n < 60000) begin
      for (int c = 0; c < NA; c++) begin
        if (issued < 1000 && ifa.c_req[c] == ifa.c_ack[c] && $urandom_range(2, 0) == 0) begin
          issue(c, 1'($urandom_range(1, 0)), {2'(c), 12'h000, 8'($urandom)},
                2'($urandom_range(3, 1)), 16'($urandom));
          issued++;
        end
      end
      tick();
      n++;
    end
    chk("rand_timeout", n < 60000, 1);
    chk("rand_done", n_done - done0, 1000);
    for (int c = 0; c < NA; c++) chk("rand_q_empty", expq[c].size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
- Shares the single 16-bit SDRAM controller port between NREQ clients that use the toggle handshake.
- Clients include the RV adapter, CPU bus and DMA/video fetch.
- Each client sees a private toggle req/ack port. The arbiter grants one client at a time, forwards its address, data and strobes, and returns read data and the ack toggle to that client.
- Sits between the client adapters and the SDRAM controller, in the memory subsystem.

Parameters:
- NREQ, 2: number of client ports (2..4).
- RR, 1: 1 = round-robin priority; 0 = fixed priority, lowest index wins.

Ports:
- clk  in  1  system clock. Single clock domain.
- resetn  in  1  reset, asynchronous assert, active-low.
- c_req  in  NREQ  per-client request toggle. Client i is pending while c_req[i] != c_ack[i].
- c_ack  out  NREQ  per-client ack toggle. Set equal to c_req[i] on completion.
- c_addr  in  NREQ*22  packed word addresses [22:1]. Client i uses bits [i*22 +: 22].
- c_ds  in  NREQ*2  packed byte enables.
- c_we  in  NREQ  per-client write enable.
- c_din  in  NREQ*16  packed write data.
- c_dout  out  NREQ*16  packed read data. Each field is registered per client.
- grant  out  2  index of the current or last granted client.
- busy  out  1  high while a forwarded transaction is outstanding.
- mem_addr  out  22  to controller, word address [22:1].
- mem_req  out  1  to controller, request toggle.
- mem_ds  out  2  to controller, byte enables.
- mem_we  out  1  to controller, write enable.
- mem_din  out  16  to controller, write data.
- mem_req_ack  in  1  from controller. Transaction done when mem_req_ack == mem_req.
- mem_dout  in  16  from controller, read data. Valid in the cycle completion is detected.

Behaviour:
- Reset (asynchronous, active-low) sets:
  - mem_req=0, mem_addr=0, mem_ds=0, mem_we=0, mem_din=0;
  - c_ack=0 and every c_dout field=0;
  - grant=0, busy=0, state=IDLE;
  - last-grant pointer=NREQ-1, so client 0 has top round-robin priority after reset.
- The SDRAM controller must be reset by the same resetn, so that mem_req_ack starts at 0.
- Reset asserted mid-transaction abandons the transaction with no completion. Clients must be reset together with the arbiter.
- pending[i] = c_req[i] ^ c_ack[i]. It is evaluated combinationally from registered c_ack.
- State IDLE:
  - If no client is pending: stay in IDLE; all mem_* outputs hold their values.
  - If any client is pending, select winner w:
    - RR=1: first pending index scanning (last+1) mod NREQ upward, with wraparound.
    - RR=0: lowest pending index.
  - For the winner: latch c_addr[w], c_ds[w], c_we[w], c_din[w] into mem_*; toggle mem_req; set grant=w and busy=1; go to BUSY.
  - mem_req toggles on the clock edge after c_req[w] is first seen toggled. Request latency is 1 cycle.
- State BUSY:
  - Wait for mem_req_ack == mem_req. mem_* outputs are held stable throughout.
  - On that cycle:
    - if mem_we=0, c_dout[grant] <= mem_dout; for writes c_dout is unchanged;
    - c_ack[grant] toggles;
    - last <= grant, busy <= 0, go to IDLE.
  - The client sees c_ack flip and valid c_dout on the same clock edge.
- Between transactions there is exactly one IDLE cycle minimum. Back-to-back grants are 1 cycle after completion.
- Requests from other clients arriving while BUSY stay pending. They are arbitrated in the next IDLE cycle; none are lost.
- Simultaneous toggles by several clients in the same cycle: one grant per IDLE cycle, by the priority rule. The others stay pending.
- Round-robin fairness: with all NREQ clients continuously pending, grants rotate 0,1,..,NREQ-1,0.
- Client rules:
  - addr, ds, we and din are sampled only at grant. They may change after c_req toggles only once c_ack matches.
  - Toggling c_req again before ack is a protocol violation. The result is undefined; the bench asserts it never happens.
- Width rules: packed field i is at [i*W +: W]. grant is zero-extended from a client index below NREQ.
- c_dout fields of non-granted clients never change.

Test Plan:
- Reset, then client 0 read at addr 0x000100. Controller returns 0xBEEF after 3 cycles. Expect:
  - mem_req toggles 1 cycle after c_req[0];
  - c_ack[0] flips and c_dout[0]=0xBEEF on the completion edge;
  - c_dout[1] stays 0.
- Client 1 write, addr 0x3FFFFF, ds=2'b10, din=0x1234. Expect:
  - mem_addr=0x3FFFFF, mem_ds=2'b10, mem_we=1, mem_din=0x1234, all stable until ack;
  - c_dout[1] unchanged.
- Clients 0 and 1 toggle in the same cycle, RR=1, after reset. Expect client 0 granted first, then client 1 one cycle after the first completion. Repeat with both pending: order is 0 then 1 again. With RR=0, client 0 always wins.
- Client 1 toggles while client 0 is BUSY. Expect:
  - no mem_req change until client 0 completes;
  - client 1 granted exactly 1 cycle later;
  - busy low for exactly one cycle between the two transactions.
- Assert resetn mid-BUSY (asynchronous, off clock edge). Expect mem_req=0, c_ack=0, busy=0 immediately. After release, a fresh client 0 request completes normally.
- Random traffic, NREQ=4, 1000 ops, against a memory model with random latency 1..8. Check:
  - every request completes exactly once;
  - read data matches the model;
  - no client waits more than 3 other grants (RR=1).
